// File: rtl/deco_pkg.sv
// deco_pkg
// Shared definitions for the Deco frame sequencer: sequencer state
// encoding and the default beat/result geometry of the Deco core.
// No ports; imported by deco_beat_serializer and deco_frame_sequencer.
package deco_pkg;

  localparam int DECO_DATA_W = 21;
  localparam int DECO_BEATS  = 4;
  localparam int DECO_OUT_W  = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SEND   = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } deco_seq_state_t;

endpackage

// File: rtl/deco_beat_serializer.sv
// deco_beat_serializer
// Holds one latched frame and plays it out on the Deco start/data port:
// BEATS data beats (lowest slice first) followed by one all-zero beat,
// with start high on every one of those BEATS+1 cycles.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - latch frame and begin a new beat sequence
//   frame       - frame payload, DATA_W*BEATS bits
//   start       - Deco start strobe
//   data        - Deco beat data, zero outside data beats
//   last_o      - high on the final (all-zero) beat cycle
module deco_beat_serializer
  import deco_pkg::*;
#(
  parameter int DATA_W = DECO_DATA_W,
  parameter int BEATS  = DECO_BEATS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [DATA_W*BEATS-1:0]  frame,
  output logic                     start,
  output logic [DATA_W-1:0]        data,
  output logic                     last_o
);

  localparam int BC_W = $clog2(BEATS + 1);
  localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(BEATS);

  logic [DATA_W*BEATS-1:0] frame_q;
  logic [BC_W-1:0]         beat_q;
  logic                    active_q;

  // Beat counter runs 0..BEATS while active; the BEATS cycle is the
  // trailing zero beat after which the sequence ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q  <= '0;
      beat_q   <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      frame_q  <= frame;
      beat_q   <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (beat_q == BEAT_LAST) begin
        active_q <= 1'b0;
      end else begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  assign start  = active_q;
  assign last_o = active_q && (beat_q == BEAT_LAST);

  // Slice mux; nothing matches on the trailing beat so it drives zero.
  always_comb begin
    data = '0;
    if (active_q) begin
      for (int k = 0; k < BEATS; k++) begin
        if (beat_q == BC_W'(k)) begin
          data = frame_q[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/deco_frame_sequencer.sv
// deco_frame_sequencer
// Runs num_frames_i frames through the Deco turbo-decoder core: fetches a
// frame with its expected result, serialises it, waits for the core
// result (or a timeout), and counts mismatches/timeouts as errors.
// Ports:
//   clk_p_i, reset_n_i            - clock, asynchronous active-low reset
//   run_i, num_frames_i           - run request and frame count
//   frm_valid_i/frm_ready_o       - frame handshake
//   frm_data_i, frm_exp_i         - frame payload and expected result
//   core_start_o, core_data_o     - to Deco start_i / data_i
//   core_data_i, core_done_i      - from Deco data_o / done_o
//   busy_o, done_o, pass_o        - run status
//   err_cnt_o, timeout_o          - saturating error count, sticky timeout
//   first_fail_o                  - {frame index, actual, expected}
// Optional feature: define DECO_SEQ_LOG_EN to capture the first failing
// frame in first_fail_o; otherwise it is tied to zero.
module deco_frame_sequencer
  import deco_pkg::*;
#(
  parameter int DATA_W  = DECO_DATA_W,
  parameter int BEATS   = DECO_BEATS,
  parameter int OUT_W   = DECO_OUT_W,
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 256
) (
  input  logic                      clk_p_i,
  input  logic                      reset_n_i,
  input  logic                      run_i,
  input  logic [CNT_W-1:0]          num_frames_i,
  input  logic                      frm_valid_i,
  output logic                      frm_ready_o,
  input  logic [DATA_W*BEATS-1:0]   frm_data_i,
  input  logic [OUT_W-1:0]          frm_exp_i,
  output logic                      core_start_o,
  output logic [DATA_W-1:0]         core_data_o,
  input  logic [OUT_W-1:0]          core_data_i,
  input  logic                      core_done_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [CNT_W-1:0]          err_cnt_o,
  output logic                      timeout_o,
  output logic [CNT_W+2*OUT_W-1:0]  first_fail_o
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  deco_seq_state_t state_q, state_d;

  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] frame_idx_q;
  logic [OUT_W-1:0] exp_q;
  logic [TMR_W-1:0] tmr_q;
  logic [CNT_W-1:0] err_q;
  logic             tmo_flag_q;
  logic             pass_q;
  logic             done_q;

  logic run_accept;
  logic frame_accept;
  logic ser_last;
  logic result;
  logic tmo;
  logic fail;
  logic last_frame;

  assign run_accept   = (state_q == IDLE) && run_i;
  assign frame_accept = (state_q == FETCH) && frm_valid_i;
  assign result       = (state_q == WAIT) && core_done_i;
  // A done on the final timer cycle wins over the timeout.
  assign tmo          = (state_q == WAIT) && !core_done_i && (tmr_q == TMR_LAST);
  assign fail         = (result && (core_data_i != exp_q)) || tmo;
  assign last_frame   = (frame_idx_q == (num_q - CNT_W'(1)));

  deco_beat_serializer #(
    .DATA_W (DATA_W),
    .BEATS  (BEATS)
  ) u_ser (
    .clk    (clk_p_i),
    .rst_n  (reset_n_i),
    .load   (frame_accept),
    .frame  (frm_data_i),
    .start  (core_start_o),
    .data   (core_data_o),
    .last_o (ser_last)
  );

  // Run sequencing: one frame at a time through fetch, send and wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run_i) state_d = (num_frames_i == '0) ? FINISH : FETCH;
      FETCH:   if (frm_valid_i) state_d = SEND;
      SEND:    if (ser_last) state_d = WAIT;
      WAIT:    if (core_done_i || tmo) state_d = last_frame ? FINISH : FETCH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Run bookkeeping. The wait timer is held at zero outside WAIT so each
  // WAIT visit starts counting from zero; SEND always precedes WAIT.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      num_q       <= '0;
      frame_idx_q <= '0;
      exp_q       <= '0;
      tmr_q       <= '0;
      err_q       <= '0;
      tmo_flag_q  <= 1'b0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == FINISH);
      if (run_accept) begin
        num_q       <= num_frames_i;
        frame_idx_q <= '0;
        err_q       <= '0;
        tmo_flag_q  <= 1'b0;
        pass_q      <= 1'b0;
      end
      if (frame_accept) begin
        exp_q <= frm_exp_i;
      end
      if (state_q == WAIT) begin
        tmr_q <= tmr_q + 1'b1;
      end else begin
        tmr_q <= '0;
      end
      if (fail && (err_q != '1)) begin
        err_q <= err_q + 1'b1;
      end
      if (tmo) begin
        tmo_flag_q <= 1'b1;
      end
      if (result || tmo) begin
        frame_idx_q <= frame_idx_q + 1'b1;
      end
      if (state_q == FINISH) begin
        pass_q <= (err_q == '0);
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign frm_ready_o = (state_q == FETCH);
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_cnt_o   = err_q;
  assign timeout_o   = tmo_flag_q;

`ifdef DECO_SEQ_LOG_EN
  logic                      logged_q;
  logic [CNT_W+2*OUT_W-1:0]  ff_q;
  logic [OUT_W-1:0]          actual;

  // A timed-out frame has no core result, so it is logged as zero.
  assign actual = tmo ? {OUT_W{1'b0}} : core_data_i;

  // Only the first failure of a run is kept.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      logged_q <= 1'b0;
      ff_q     <= '0;
    end else if (run_accept) begin
      logged_q <= 1'b0;
      ff_q     <= '0;
    end else if (fail && !logged_q) begin
      logged_q <= 1'b1;
      ff_q     <= {frame_idx_q, actual, exp_q};
    end
  end

  assign first_fail_o = ff_q;
`else
  assign first_fail_o = '0;
`endif

endmodule
